// File: rtl/param_register_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : param_register_file
//  Description : Parametrised register file with NUM_RD registered read
//                ports, two prioritised write ports, an optional hardwired
//                zero entry, optional write-to-read bypass and a hardware
//                clear sequencer that zeroes storage after reset or on request.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_req,
    output logic                      ready,
    input  logic                      we0,
    input  logic [AW-1:0]             waddr0,
    input  logic [WIDTH-1:0]          wdata0,
    input  logic                      we1,
    input  logic [AW-1:0]             waddr1,
    input  logic [WIDTH-1:0]          wdata1,
    input  logic [NUM_RD-1:0]         re,
    input  logic [NUM_RD*AW-1:0]      raddr,
    output logic [NUM_RD*WIDTH-1:0]   rdata,
    output logic [NUM_RD-1:0]         rvalid
);

    // One extra bit so a non-power-of-two DEPTH can be range-checked.
    localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST  = AW'(DEPTH-1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_clr_ptr;
    logic [AW-1:0]      w_clr_ptr_nxt;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_accept;
    logic               w_wr0_en;
    logic               w_wr1_en;

    // An address holds real storage: inside the array and not the zero entry.
    function automatic logic f_live(input logic [AW-1:0] a);
        return ({1'b0, a} < c_DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    // Reads and writes are only honoured in RUN on a cycle with no clear request.
    assign w_accept = rst_n && (r_state == ST_RUN) && !clear_req;
    assign w_wr0_en = w_accept && we0 && f_live(waddr0);
    assign w_wr1_en = w_accept && we1 && f_live(waddr1);
    assign ready    = (r_state == ST_RUN);

    // State and sweep pointer register; reset restarts the sweep at entry 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    // Next-state logic: sweep every entry once, then run until a clear request.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_clr_ptr_nxt = r_clr_ptr + 1'b1;
                if (r_clr_ptr == c_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_ptr_nxt = '0;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_ptr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_ptr_nxt = '0;
            end
        endcase
    end

    // Storage update: sweep writes zero; otherwise port 1 is applied last so it wins.
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == ST_CLEAR)) begin
            r_mem[r_clr_ptr] <= '0;
        end else begin
            if (w_wr0_en) r_mem[waddr0] <= wdata0;
            if (w_wr1_en) r_mem[waddr1] <= wdata1;
        end
    end

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [AW-1:0]    w_ra;
        logic [WIDTH-1:0] w_src;
        logic [WIDTH-1:0] r_q;
        logic             r_v;

        assign w_ra = raddr[gi*AW +: AW];

        // Read source: dead address -> 0, then same-cycle write data, then storage.
        always_comb begin
            w_src = '0;
            if (f_live(w_ra)) begin
                if (BYPASS && w_wr1_en && (waddr1 == w_ra))
                    w_src = wdata1;
                else if (BYPASS && w_wr0_en && (waddr0 == w_ra))
                    w_src = wdata0;
                else
                    w_src = r_mem[w_ra];
            end
        end

        // Registered read port; output is zeroed whenever storage is not valid.
        always_ff @(posedge clk) begin
            if (!rst_n || (r_state != ST_RUN) || clear_req) begin
                r_q <= '0;
                r_v <= 1'b0;
            end else begin
                r_v <= re[gi];
                if (re[gi]) r_q <= w_src;
            end
        end

        assign rdata[gi*WIDTH +: WIDTH] = r_q;
        assign rvalid[gi]               = r_v;
    end

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_param_register_file
//  Description : Scoreboard bench for param_register_file. Instance A uses the
//                default build; instance B is DEPTH=20, BYPASS=0, one read port
//                and shares the same stimulus (port 0 only).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_req = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  waddr0 = '0, waddr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic [1:0]  re = '0;
    logic [9:0]  raddr = '0;
    logic        ready_a, ready_b;
    logic [63:0] rdata_a;
    logic [1:0]  rvalid_a;
    logic [31:0] rdata_b;
    logic [0:0]  rvalid_b;

    logic [31:0] q0[$], q1[$], qb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    param_register_file u_dut_a (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
    );

    param_register_file #(.WIDTH(32), .DEPTH(20), .NUM_RD(1), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re[0:0]), .raddr(raddr[4:0]), .rdata(rdata_b), .rvalid(rvalid_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented read result is popped from its port queue and compared.
    always @(negedge clk) begin
        if (rvalid_a[0] === 1'b1) begin
            if (q0.size() == 0) check("a_rd0_unexpected", 32'd1, 32'd0);
            else check("a_rd0_data", rdata_a[31:0], q0.pop_front());
        end
        if (rvalid_a[1] === 1'b1) begin
            if (q1.size() == 0) check("a_rd1_unexpected", 32'd1, 32'd0);
            else check("a_rd1_data", rdata_a[63:32], q1.pop_front());
        end
        if (rvalid_b[0] === 1'b1) begin
            if (qb.size() == 0) check("b_rd0_unexpected", 32'd1, 32'd0);
            else check("b_rd0_data", rdata_b, qb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One stimulus cycle; when exp=1 the reads issued are expected to complete.
    task automatic cyc(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [1:0] r, input logic [4:0] ra0, input logic [4:0] ra1,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] eb,
                       input logic clr, input logic exp);
        we0 = w0; waddr0 = a0; wdata0 = d0;
        we1 = w1; waddr1 = a1; wdata1 = d1;
        re = r; raddr = {ra1, ra0}; clear_req = clr;
        if (exp && r[0]) begin q0.push_back(e0); qb.push_back(eb); end
        if (exp && r[1]) q1.push_back(e1);
        tick();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Count sweep edges and check ready rises on exactly the right one for each build.
    task automatic sweep_check(input string tag);
        for (int k = 1; k <= 32; k++) begin
            idle();
            check({tag, "_ready_a"}, {31'd0, ready_a}, {31'd0, k == 32});
            check({tag, "_ready_b"}, {31'd0, ready_b}, {31'd0, k >= 20});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset, sweep length, all entries read zero
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_ready", {31'd0, ready_a}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid_a}, 32'd0);
        check("rst_rdata_lo", rdata_a[31:0], 32'd0);
        check("rst_rdata_hi", rdata_a[63:32], 32'd0);
        sweep_check("t1");
        for (int a = 0; a < 32; a++)
            cyc(0, 0, 0, 0, 0, 0, 2'b11, 5'(a), 5'(31 - a), 0, 0, 0, 0, 1);
        idle();

        // T2: write then read back with one-cycle latency
        cyc(1, 5, 32'hDEADBEEF, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 1);
        check("t2_rvalid", {30'd0, rvalid_a}, 32'd1);

        // T3: same-address write conflict, port 1 wins; bypass on A, old value on B
        cyc(1, 7, 32'h11, 1, 7, 32'h22, 2'b11, 7, 7, 32'h22, 32'h22, 32'h0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 2'b11, 7, 5, 32'h22, 32'hDEADBEEF, 32'h22, 0, 1);
        cyc(1, 9, 32'h99, 0, 0, 0, 2'b01, 9, 0, 32'h99, 0, 32'h0, 0, 1);
        cyc(1, 10, 32'hA, 1, 11, 32'hB, 2'b01, 9, 0, 32'h99, 0, 32'h99, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 2'b11, 10, 11, 32'hA, 32'hB, 32'hA, 0, 1);

        // T4: zero register ignores writes and bypass; addr 31 is out of range for B
        cyc(1, 31, 32'h31313131, 1, 0, 32'hFFFFFFFF, 2'b01, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 2'b11, 0, 31, 0, 32'h31313131, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 25, 32'h25, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b01, 25, 0, 32'h25, 0, 32'h0, 0, 1);
        idle();
        check("hold_rdata0", rdata_a[31:0], 32'h25);
        check("hold_rvalid", {30'd0, rvalid_a}, 32'd0);

        // T5: clear request drops that edge's traffic and sweeps; sweep-time traffic ignored
        cyc(1, 3, 32'hA5A5A5A5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 2'b11, 3, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 1);
        cyc(1, 4, 32'h44, 0, 0, 0, 2'b11, 3, 3, 0, 0, 0, 1, 0);
        check("clr_ready", {31'd0, ready_a}, 32'd0);
        check("clr_rdata_lo", rdata_a[31:0], 32'd0);
        check("clr_rdata_hi", rdata_a[63:32], 32'd0);
        check("clr_rvalid", {30'd0, rvalid_a}, 32'd0);
        check("clr_rdata_b", rdata_b, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            cyc(k < 20, 3, 32'h1, 0, 0, 0, (k < 20) ? 2'b11 : 2'b00, 3, 3, 0, 0, 0, k < 20, 0);
            check("t5_ready_a", {31'd0, ready_a}, {31'd0, k == 32});
            check("t5_ready_b", {31'd0, ready_b}, {31'd0, k >= 20});
        end
        cyc(0, 0, 0, 0, 0, 0, 2'b11, 3, 4, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 2'b11, 7, 5, 0, 0, 0, 0, 1);

        // T6: reset in the middle of a sweep restarts it from entry 0
        cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 1; k < 10; k++) idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_ready", {31'd0, ready_a}, 32'd0);
        sweep_check("t6");
        cyc(0, 0, 0, 0, 0, 0, 2'b11, 10, 31, 0, 0, 0, 0, 1);
        idle();
        idle();

        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        check("qb_drained", qb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
